uart_tx_scheduler: RTL

- Round-robin scheduler that shares one UART transmitter and its baud generator among NREQ byte requesters.
- Per frame it accepts one byte plus a 2-bit baud selection from the winning requester, drives the transmitter's data, selection and start-strobe inputs, and tracks the frame to completion.
- Sits between the host-side byte sources and the uarttransmitter/baud_gen pair.
- Reports frame completion and start timeouts.

---
 rtl/uart_tx_scheduler.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter and baud generator among
// NREQ byte requesters; tracks each frame to completion or start timeout.
module uart_tx_scheduler #(
    parameter int NREQ         = 4,
    parameter int DW           = 8,
    parameter int BUSY_TIMEOUT = 16,
    parameter int IDW          = 2
) (
    input  logic                 ipclk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic [NREQ*2-1:0]    req_sel,
    output logic [NREQ-1:0]      req_ready,
    output logic [DW-1:0]        uart_data,
    output logic [1:0]           uart_sel,
    output logic                 uart_start,
    input  logic                 uart_busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 frame_done,
    output logic                 timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    localparam int CW = 8;
    // The counter is checked before its increment, so expiry lands exactly
    // BUSY_TIMEOUT cycles after the start strobe.
    localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 2);

    state_e            state_q, state_d;
    logic [IDW-1:0]    rr_q, rr_d;
    logic [IDW-1:0]    gid_q, gid_d;
    logic [NREQ-1:0]   ready_q, ready_d;
    logic [DW-1:0]     data_q, data_d;
    logic [1:0]        sel_q, sel_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic              tout_q, tout_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [DW-1:0]     data_arr [NREQ];
    logic [1:0]        sel_arr  [NREQ];
    logic              found;
    logic [IDW-1:0]    win;
    logic [IDW-1:0]    idx;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            data_arr[i] = req_data[i*DW +: DW];
            sel_arr[i]  = req_sel[i*2 +: 2];
        end
    end

    // Search starts at rr_q and wraps, so the last grantee has lowest priority.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(rr_q) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gid_d   = gid_q;
        ready_d = '0;
        data_d  = data_q;
        sel_d   = sel_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        tout_d  = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (!uart_busy && found) begin
                    data_d       = data_arr[win];
                    sel_d        = sel_arr[win];
                    gid_d        = win;
                    rr_d         = IDW'((int'(win) + 1) % NREQ);
                    ready_d[win] = 1'b1;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                start_d = 1'b1;
                state_d = START;
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (uart_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    tout_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!uart_busy) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ipclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gid_q   <= '0;
            ready_q <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            tout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gid_q   <= gid_d;
            ready_q <= ready_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            start_q <= start_d;
            done_q  <= done_d;
            tout_q  <= tout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready   = ready_q;
    assign uart_data   = data_q;
    assign uart_sel    = sel_q;
    assign uart_start  = start_q;
    assign grant_id    = gid_q;
    assign frame_done  = done_q;
    assign timeout_err = tout_q;

endmodule
